// File: rtl/lib_cell_pkg.sv
// rtl/lib_cell_pkg.sv - shared constants, golden truth tables and FSM states for the library-cell BIST
package lib_cell_pkg;

  localparam int CELL_COUNT = 12;

  // Entry k-1 is cell Nk; bit i is the expected x for {y,z} = i.
  localparam logic [11:0][3:0] TRUTH_TABLE = {
    4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b1110, 4'b0001,
    4'b1101, 4'b1011, 4'b0111, 4'b0010, 4'b0100, 4'b1000
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic golden_bit(input logic [3:0] idx, input logic [1:0] pat);
    return TRUTH_TABLE[4'(idx - 4'd1)][pat];
  endfunction

endpackage

// File: rtl/lib_cell_pattern_gen.sv
// rtl/lib_cell_pattern_gen.sv - 2-bit input pattern counter plus settle timer for one cell under test
module lib_cell_pattern_gen #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       drive,
  input  logic       advance,
  output logic [1:0] pattern,
  output logic       settle_done,
  output logic       last_pattern
);

  logic [3:0] settle_cnt;

  assign settle_done  = drive && (settle_cnt == 4'(SETTLE_CYCLES - 1));
  assign last_pattern = (pattern == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern    <= 2'd0;
      settle_cnt <= 4'd0;
    end else if (clear) begin
      pattern    <= 2'd0;
      settle_cnt <= 4'd0;
    end else begin
      if (drive)
        settle_cnt <= settle_done ? 4'd0 : settle_cnt + 4'd1;
      if (advance)
        pattern <= pattern + 2'd1;
    end
  end

endmodule

// File: rtl/lib_cell_bist_ctrl.sv
// rtl/lib_cell_bist_ctrl.sv - walks enabled library cells through all input patterns and scores cut_x
module lib_cell_bist_ctrl
  import lib_cell_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] cell_mask,
  output logic [3:0]  cut_sel,
  output logic        cut_y,
  output logic        cut_z,
  input  logic        cut_x,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [11:0] fail_map,
  output logic [5:0]  err_cnt
);

  state_t      state, state_next;
  logic [3:0]  idx;
  logic [3:0]  idx_m1;
  logic [11:0] mask_q;
  logic [1:0]  pattern;
  logic        settle_done;
  logic        last_pattern;
  logic        enabled;
  logic        last_cell;
  logic        active;
  logic        mismatch;

  assign idx_m1    = idx - 4'd1;
  assign enabled   = mask_q[idx_m1];
  assign last_cell = (idx == 4'(CELL_COUNT));
  assign active    = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign mismatch  = (state == ST_SAMPLE) && (cut_x != golden_bit(idx, pattern));

  assign busy    = (state == ST_SETUP) || active;
  assign cut_sel = active ? idx : 4'd0;
  assign cut_y   = active && pattern[1];
  assign cut_z   = active && pattern[0];

  lib_cell_pattern_gen #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_pattern_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (state == ST_SETUP),
    .drive        (state == ST_DRIVE),
    .advance      (state == ST_SAMPLE),
    .pattern      (pattern),
    .settle_done  (settle_done),
    .last_pattern (last_pattern)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SETUP;
      ST_SETUP:  if (enabled) state_next = ST_DRIVE;
                 else if (last_cell) state_next = ST_DONE;
      ST_DRIVE:  if (settle_done) state_next = ST_SAMPLE;
      ST_SAMPLE: if (!last_pattern) state_next = ST_DRIVE;
                 else if (last_cell) state_next = ST_DONE;
                 else state_next = ST_SETUP;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= 4'd1;
      mask_q   <= 12'd0;
      fail_map <= 12'd0;
      err_cnt  <= 6'd0;
      pass     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      // done and pass land together one cycle after the DONE state
      done  <= (state == ST_DONE);
      if (state == ST_DONE)
        pass <= (fail_map == 12'd0);
      if (state == ST_IDLE && start) begin
        mask_q   <= cell_mask;
        fail_map <= 12'd0;
        err_cnt  <= 6'd0;
        idx      <= 4'd1;
        pass     <= 1'b0;
      end
      if (state == ST_SETUP && !enabled && !last_cell)
        idx <= idx + 4'd1;
      if (state == ST_SAMPLE && last_pattern && !last_cell)
        idx <= idx + 4'd1;
      if (mismatch) begin
        fail_map[idx_m1] <= 1'b1;
        if (err_cnt != 6'h3F)
          err_cnt <= err_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_lib_cell_bist_ctrl.sv
// tb/tb_lib_cell_bist_ctrl.sv - scoreboard bench for lib_cell_bist_ctrl with a behavioural cell array
module tb_lib_cell_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] cell_mask = 12'd0;
  logic [3:0]  cut_sel;
  logic        cut_y, cut_z, cut_x;
  logic        busy, done, pass;
  logic [11:0] fail_map;
  logic [5:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int sel_seen = 0;

  logic [3:0] tt_b [1:12];
  logic [3:0] fault_cell = 4'd0;
  logic       fault_val = 1'b0;

  typedef struct {
    int          lat;
    logic        pass;
    logic [11:0] fmap;
    logic [5:0]  errs;
  } exp_t;
  exp_t sb[$];

  lib_cell_bist_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cell_mask(cell_mask),
    .cut_sel(cut_sel), .cut_y(cut_y), .cut_z(cut_z), .cut_x(cut_x),
    .busy(busy), .done(done), .pass(pass), .fail_map(fail_map), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cells, with one optional stuck-at output
  always_comb begin
    cut_x = 1'b0;
    if (cut_sel >= 4'd1 && cut_sel <= 4'd12) begin
      if (cut_sel == fault_cell) cut_x = fault_val;
      else                       cut_x = tt_b[cut_sel][{cut_y, cut_z}];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && busy && cut_sel != 4'd0) sel_seen++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_latency", cyc - accept_cyc, e.lat);
        chk("pass", int'(pass), int'(e.pass));
        chk("fail_map", int'(fail_map), int'(e.fmap));
        chk("err_cnt", int'(err_cnt), int'(e.errs));
      end
    end
  end

  task automatic run(input logic [11:0] m, input int lat, input logic p,
                     input logic [11:0] fm, input logic [5:0] ec);
    exp_t e;
    e.lat = lat; e.pass = p; e.fmap = fm; e.errs = ec;
    sb.push_back(e);
    @(negedge clk);
    cell_mask = m;
    start = 1'b1;
    @(posedge clk);
    #1 accept_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_fail_map"}, int'(fail_map), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_cut_sel"}, int'(cut_sel), 0);
    chk({tag, "_cut_yz"}, int'({cut_y, cut_z}), 0);
  endtask

  initial begin
    tt_b[1]  = 4'b1000; tt_b[2]  = 4'b0100; tt_b[3]  = 4'b0010; tt_b[4]  = 4'b0111;
    tt_b[5]  = 4'b1011; tt_b[6]  = 4'b1101; tt_b[7]  = 4'b0001; tt_b[8]  = 4'b1110;
    tt_b[9]  = 4'b1100; tt_b[10] = 4'b0011; tt_b[11] = 4'b1111; tt_b[12] = 4'b0000;

    #12;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All cells fault-free
    run(12'hFFF, 157, 1'b1, 12'h000, 6'd0);
    wait_done();

    // N4 output stuck at 1 only disagrees on {y,z}=11
    fault_cell = 4'd4; fault_val = 1'b1;
    run(12'hFFF, 157, 1'b0, 12'h008, 6'd1);
    wait_done();

    // N11 stuck at 0 disagrees on all four patterns
    fault_cell = 4'd11; fault_val = 1'b0;
    run(12'h400, 25, 1'b0, 12'h400, 6'd4);
    wait_done();
    fault_cell = 4'd0;

    // Empty mask: only the 12 SETUP cycles
    sel_seen = 0;
    run(12'h000, 13, 1'b1, 12'h000, 6'd0);
    wait_done();
    chk("mask0_cut_sel_idle", sel_seen, 0);

    // Single cell: check the drive sequence, and that a mid-run mask change is ignored
    run(12'h001, 25, 1'b1, 12'h000, 6'd0);
    chk("n1_sel_off0", int'(cut_sel), 0);
    for (int o = 1; o <= 13; o++) begin
      @(negedge clk);
      chk($sformatf("n1_sel_off%0d", o), int'(cut_sel), (o <= 12) ? 1 : 0);
      chk($sformatf("n1_yz_off%0d", o), int'({cut_y, cut_z}), (o <= 12) ? (o - 1) / 3 : 0);
      if (o == 5) cell_mask = 12'hFFF;
    end
    wait_done();

    // start pulse mid-run is ignored
    run(12'hFFF, 157, 1'b1, 12'h000, 6'd0);
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();

    // Reset at cycle 40 aborts with no done pulse
    fault_cell = 4'd2; fault_val = 1'b1;
    run(12'hFFF, 157, 1'b0, 12'h002, 6'd3);
    repeat (39) @(negedge clk);
    chk("pre_reset_err_cnt", int'(err_cnt), 3);
    chk("pre_reset_fail_map", int'(fail_map), 12'h002);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", int'(done), 0);
    fault_cell = 4'd0;
    run(12'hFFF, 157, 1'b1, 12'h000, 6'd0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
